// File: rtl/sr_pulse_ctrl_pkg.sv
// Shared definitions for the SR latch pulse controller.
package sr_pulse_ctrl_pkg;

   // Controller states; encodings match the legacy header values.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PULSE_S = 2'd1,
      PULSE_R = 2'd2,
      HOLD    = 2'd3
   } ctrl_state_t;

endpackage

// File: rtl/sr_pulse_ctrl_debounce_sync.sv
// Two-flop synchronizer plus counter debouncer for one raw push-button.
module debounce_sync #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned CNT_W           = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic level,
   output logic rise
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_a;
   logic             sync_b;
   logic [CNT_W-1:0] cnt;

   // Synchronize, then accept a new level only after it has persisted DEBOUNCE_CYCLES cycles.
   // rise is registered alongside level so it is high in the first cycle of the new high level.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_a <= 1'b0;
         sync_b <= 1'b0;
         level  <= 1'b0;
         rise   <= 1'b0;
         cnt    <= '0;
      end else begin
         sync_a <= btn_raw;
         sync_b <= sync_a;
         rise   <= 1'b0;
         if (sync_b == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            level <= sync_b;
            rise  <= sync_b;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/sr_pulse_ctrl.sv
// Drives mutually exclusive fixed-width S/R pulses into a NOR SR latch from two
// debounced buttons, and flags a sticky error when latch Q disagrees after a pulse.
module sr_pulse_ctrl
   import sr_pulse_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned PULSE_CYCLES    = 2,
   parameter int unsigned HOLDOFF_CYCLES  = 2,
   parameter int unsigned CNT_W           = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic set_btn,
   input  logic reset_btn,
   input  logic q_fb,
   output logic S,
   output logic R,
   output logic busy,
   output logic conflict,
   output logic err
);

   localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF_CYCLES - 1);

   ctrl_state_t      state;
   logic [CNT_W-1:0] cnt;
   logic             expected_q;
   logic             set_level;
   logic             set_rise;
   logic             reset_level;
   logic             reset_rise;
   logic             set_req;
   logic             reset_req;

   debounce_sync #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_set_db (
      .clk     (clk),
      .reset   (reset),
      .btn_raw (set_btn),
      .level   (set_level),
      .rise    (set_rise)
   );

   debounce_sync #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_reset_db (
      .clk     (clk),
      .reset   (reset),
      .btn_raw (reset_btn),
      .level   (reset_level),
      .rise    (reset_rise)
   );

   // rise always coincides with a high level; qualifying keeps requests tied to the debounced level.
   assign set_req   = set_rise & set_level;
   assign reset_req = reset_rise & reset_level;

   // Pulse sequencer: accept one request in IDLE, pulse, settle, then check latch Q.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         expected_q <= 1'b0;
         S          <= 1'b0;
         R          <= 1'b0;
         busy       <= 1'b0;
         conflict   <= 1'b0;
         err        <= 1'b0;
      end else begin
         conflict <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (set_req && reset_req) begin
                  conflict <= 1'b1;
               end else if (set_req) begin
                  state      <= PULSE_S;
                  S          <= 1'b1;
                  busy       <= 1'b1;
                  expected_q <= 1'b1;
               end else if (reset_req) begin
                  state      <= PULSE_R;
                  R          <= 1'b1;
                  busy       <= 1'b1;
                  expected_q <= 1'b0;
               end
            end
            PULSE_S, PULSE_R: begin
               if (cnt == PULSE_LAST) begin
                  S     <= 1'b0;
                  R     <= 1'b0;
                  state <= HOLD;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            HOLD: begin
               if (cnt == HOLD_LAST) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  cnt   <= '0;
                  if (q_fb != expected_q) err <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
